m_7seg_scan: RTL and testbench



---
 rtl/m_7seg_scan.sv | 113 +++++++++++
 tb/tb_m_7seg_scan.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/m_7seg_scan.sv
// Time-multiplexed multi-digit 7-segment driver: hex/BCD decode, leading-zero
// suppression, per-digit decimal point, and a blank cycle at the start of each slot.
module m_7seg_scan #(
  parameter int NDIGITS    = 4,
  parameter int DIV        = 1000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                   w_clk,
  input  logic                   w_rst,
  input  logic                   w_we,
  input  logic [4*NDIGITS-1:0]   w_data,
  input  logic [NDIGITS-1:0]     w_dp,
  input  logic                   w_hex,
  input  logic                   w_lzs,
  output logic [6:0]             r_seg,
  output logic                   r_dp,
  output logic [NDIGITS-1:0]     r_an,
  output logic [2:0]             r_idx
);
  localparam int   PW  = $clog2(DIV);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [PW-1:0]                 p;
  logic [2:0]                    k;
  logic [NDIGITS-1:0][3:0]       data_q;
  logic [NDIGITS-1:0]            dp_q;
  logic                          hex_q, lzs_q;

  logic [NDIGITS-1:0]            zero_up;
  logic [NDIGITS-1:0][6:0]       seg_d;
  logic [6:0]                    seg_k;
  logic                          dp_k;
  logic [NDIGITS-1:0]            an_k;

  function automatic logic [6:0] dec7(input logic [3:0] n, input logic hex);
    case (n)
      4'h0: dec7 = 7'b1111110;
      4'h1: dec7 = 7'b0110000;
      4'h2: dec7 = 7'b1101101;
      4'h3: dec7 = 7'b1111001;
      4'h4: dec7 = 7'b0110011;
      4'h5: dec7 = 7'b1011011;
      4'h6: dec7 = 7'b1011111;
      4'h7: dec7 = 7'b1110000;
      4'h8: dec7 = 7'b1111111;
      4'h9: dec7 = 7'b1111011;
      4'hA: dec7 = hex ? 7'b1110111 : 7'b0000000;
      4'hB: dec7 = hex ? 7'b0011111 : 7'b0000000;
      4'hC: dec7 = hex ? 7'b1001110 : 7'b0000000;
      4'hD: dec7 = hex ? 7'b0111101 : 7'b0000000;
      4'hE: dec7 = hex ? 7'b1001111 : 7'b0000000;
      default: dec7 = hex ? 7'b1000111 : 7'b0000000;
    endcase
  endfunction

  // zero_up[i]: every nibble from digit i up to the top is zero
  for (genvar i = 0; i < NDIGITS; i++) begin : g_dig
    assign zero_up[i] = ((data_q >> (4*i)) == '0);
    assign seg_d[i]   = (lzs_q && (i != 0) && zero_up[i]) ? 7'b0 : dec7(data_q[i], hex_q);
  end

  always_comb begin
    seg_k = '0;
    dp_k  = 1'b0;
    an_k  = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (k == 3'(i)) begin
        seg_k   = seg_d[i];
        dp_k    = dp_q[i];
        an_k[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      p      <= '0;
      k      <= '0;
      data_q <= '0;
      dp_q   <= '0;
      hex_q  <= 1'b0;
      lzs_q  <= 1'b0;
      r_seg  <= {7{INV}};
      r_dp   <= INV;
      r_an   <= {NDIGITS{INV}};
      r_idx  <= '0;
    end else begin
      if (p == PW'(DIV-1)) begin
        p <= '0;
        k <= (k == 3'(NDIGITS-1)) ? 3'd0 : k + 3'd1;
      end else begin
        p <= p + PW'(1);
      end
      if (w_we) begin
        data_q <= w_data;
        dp_q   <= w_dp;
        hex_q  <= w_hex;
        lzs_q  <= w_lzs;
      end
      r_idx <= k;
      // first cycle of each slot is dark so the previous digit cannot ghost
      if (p == '0) begin
        r_seg <= {7{INV}};
        r_dp  <= INV;
        r_an  <= {NDIGITS{INV}};
      end else begin
        r_seg <= seg_k ^ {7{INV}};
        r_dp  <= dp_k ^ INV;
        r_an  <= an_k ^ {NDIGITS{INV}};
      end
    end
  end
endmodule

// File: tb/tb_m_7seg_scan.sv
// Bench for m_7seg_scan: two instances (active-high and active-low pins) checked
// every cycle against a time-based model of the scan, latch and decode rules.
module tb_m_7seg_scan;
  localparam int N = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic        hex = 1'b0;
  logic        lzs = 1'b0;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [3:0] an0, an1;
  logic [2:0] idx0, idx1;

  m_7seg_scan #(.NDIGITS(N), .DIV(D), .ACTIVE_LOW(0)) dut0 (
    .w_clk(clk), .w_rst(rst), .w_we(we), .w_data(data), .w_dp(dp), .w_hex(hex), .w_lzs(lzs),
    .r_seg(seg0), .r_dp(dp0), .r_an(an0), .r_idx(idx0));
  m_7seg_scan #(.NDIGITS(N), .DIV(D), .ACTIVE_LOW(1)) dut1 (
    .w_clk(clk), .w_rst(rst), .w_we(we), .w_data(data), .w_dp(dp), .w_hex(hex), .w_lzs(lzs),
    .r_seg(seg1), .r_dp(dp1), .r_an(an1), .r_idx(idx1));

  always #5 clk = ~clk;

  logic [14:0] got0, got1, exp0, exp1;
  assign got0 = {seg0, dp0, an0, idx0};
  assign got1 = {seg1, dp1, an1, idx1};

  int checks = 0;
  int failures = 0;

  // model: time since reset plus the latched display word
  int          t = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0;
  logic        m_hex = 1'b0, m_lzs = 1'b0;

  function automatic logic [6:0] glyph(input int n, input logic h);
    logic [6:0] tbl [16];
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
            7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    if (!h && n >= 10) return 7'b0;
    return tbl[n];
  endfunction

  // one clock: predict outputs from pre-edge state, clock, then update model
  task automatic tick();
    int pp, kk, nib;
    logic [6:0] s;
    pp = t % D;
    kk = (t / D) % N;
    if (rst) exp0 = '0;
    else if (pp == 0) exp0 = {7'b0, 1'b0, 4'b0, 3'(kk)};
    else begin
      nib = int'((m_data >> (4*kk)) & 16'hF);
      s = glyph(nib, m_hex);
      if (m_lzs && kk >= 1 && (m_data >> (4*kk)) == 16'h0) s = 7'b0;
      exp0 = {s, m_dp[kk], 4'(1 << kk), 3'(kk)};
    end
    exp1 = exp0 ^ {7'h7F, 1'b1, 4'hF, 3'b000};
    @(posedge clk);
    if (rst) begin
      t = 0; m_data = '0; m_dp = '0; m_hex = 1'b0; m_lzs = 1'b0;
    end else begin
      t++;
      if (we) begin m_data = data; m_dp = dp; m_hex = hex; m_lzs = lzs; end
    end
    #1;
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p, input logic h, input logic l);
    data = d; dp = p; hex = h; lzs = l; we = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (got0 !== exp0 || got0 !== 15'h0) begin failures++; $display("FAIL reset0 got=%h exp=%h", got0, exp0); end
      checks++;
      if (got1 !== exp1) begin failures++; $display("FAIL reset1 got=%h exp=%h", got1, exp1); end
    end
    rst = 1'b0;
  endtask

  task automatic test_hex_1234();
    load(16'h1234, 4'b0000, 1'b1, 1'b0);
    tick();
    we = 1'b0;
    repeat (2*N*D) begin
      tick();
      checks++;
      if (got0 !== exp0) begin failures++; $display("FAIL hex1234 got=%h exp=%h t=%0d", got0, exp0, t); end
      checks++;
      if (got1 !== exp1) begin failures++; $display("FAIL hex1234_al got=%h exp=%h t=%0d", got1, exp1, t); end
    end
  endtask

  task automatic test_abcd();
    for (int h = 1; h >= 0; h--) begin
      load(16'hABCD, 4'b0000, 1'(h), 1'b0);
      tick();
      we = 1'b0;
      repeat (N*D + 2) begin
        tick();
        checks++;
        if (got0 !== exp0) begin failures++; $display("FAIL abcd hex=%0d got=%h exp=%h", h, got0, exp0); end
        if (h == 0 && an0 != 4'b0) begin
          checks++;
          if (seg0 !== 7'b0) begin failures++; $display("FAIL bcd_blank seg=%b exp=0000000", seg0); end
        end
      end
    end
  endtask

  task automatic test_lzs();
    logic [15:0] vals [2];
    vals = '{16'h0005, 16'h0000};
    for (int v = 0; v < 2; v++) begin
      load(vals[v], 4'b0100, 1'b1, 1'b1);
      tick();
      we = 1'b0;
      repeat (N*D + 2) begin
        tick();
        checks++;
        if (got0 !== exp0) begin failures++; $display("FAIL lzs v=%h got=%h exp=%h", vals[v], got0, exp0); end
        checks++;
        if (got1 !== exp1) begin failures++; $display("FAIL lzs_al v=%h got=%h exp=%h", vals[v], got1, exp1); end
      end
    end
  endtask

  task automatic test_midslot();
    int guard = 0;
    load(16'h1111, 4'b0000, 1'b1, 1'b0);
    tick();
    we = 1'b0;
    while (t % D != 2 && guard < 16) begin tick(); guard++; end
    load(16'h8765, 4'b1001, 1'b1, 1'b0);
    tick();
    we = 1'b0;
    repeat (3*N*D) begin
      tick();
      checks++;
      if (got0 !== exp0) begin failures++; $display("FAIL midslot got=%h exp=%h t=%0d", got0, exp0, t); end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    load(16'h4321, 4'b1111, 1'b1, 1'b0);
    tick();
    we = 1'b0;
    while (t % (N*D) != 9 && guard < 32) begin tick(); guard++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (got0 !== 15'h0) begin failures++; $display("FAIL rstmid0 got=%h exp=0000", got0); end
    checks++;
    if (got1 !== 15'h7FF8) begin failures++; $display("FAIL rstmid1 got=%h exp=7ff8", got1); end
    repeat (N*D + 4) begin
      tick();
      checks++;
      if (got0 !== exp0) begin failures++; $display("FAIL rstscan got=%h exp=%h", got0, exp0); end
      checks++;
      if (got1 !== exp1) begin failures++; $display("FAIL rstscan_al got=%h exp=%h", got1, exp1); end
    end
  endtask

  task automatic test_random();
    repeat (400) begin
      we = ($urandom_range(0, 7) == 0);
      data = 16'($urandom);
      if ($urandom_range(0, 1) == 1) data = data & 16'h00FF;
      dp = 4'($urandom);
      hex = 1'($urandom);
      lzs = 1'($urandom);
      tick();
      checks++;
      if (got0 !== exp0) begin failures++; $display("FAIL random got=%h exp=%h t=%0d", got0, exp0, t); end
      checks++;
      if (got1 !== exp1) begin failures++; $display("FAIL random_al got=%h exp=%h t=%0d", got1, exp1, t); end
    end
    we = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_hex_1234();
    test_abcd();
    test_lzs();
    test_midslot();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
